dmem_bus_master: RTL and testbench
==================================

// Module: dmem_bus_master
// PURPOSE
//   Core-side initiator for the data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
//   Accepts one load/store request at a time from the execute/memory stage,
//   runs the bus handshake and waits any number of cycles for ACKD_n.
//   Formats store data, sign/zero-extends load data and returns one response.
//   Sits inside top between the datapath and the external data-memory port.
// PARAMETERS
//   BIT_WIDTH       32   bus/data width
//   TIMEOUT_CYCLES  256  bus cycles without ACKD_n before abort (error response)
// PORTS
//   clk         in   1   clock, rising-edge
//   rst         in   1   synchronous reset, active-low
//   req_valid   in   1   request present
//   req_ready   out  1   block can accept a request this cycle
//   req_write   in   1   1=store, 0=load
//   req_funct3  in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data, right-justified
//   resp_valid  out  1   one-cycle completion pulse
//   resp_err    out  1   qualifies resp_valid: misaligned/illegal/timeout
//   resp_rdata  out  32  extended load data (0 for stores and errors)
//   DAD         out  32  bus address
//   MREQ        out  1   bus request
//   WRITE       out  1   1=write cycle
//   SIZE        out  2   00 word, 01 half, 10 byte
//   DDT         inout 32 bus data; driven only while MREQ&&WRITE, else 'z
//   ACKD_n      in   1   memory acknowledge, active-low
// BEHAVIOUR
//   Reset (rst==0 at edge): state IDLE; MREQ=0 WRITE=0 SIZE=00 DAD=0; DDT='z;
//     req_ready=1 resp_valid=0 resp_err=0 resp_rdata=0; wait counter=0.
//     Reset mid-transaction aborts it: MREQ low after that edge, no response.
//   States: IDLE -> BUS -> IDLE. req_ready==1 only in IDLE.
//   IDLE: on req_valid&&req_ready latch addr/funct3/write/wdata.
//     Illegal: H/HU with addr[0]!=0; W with addr[1:0]!=0; funct3 not in list;
//     store with funct3 100/101. Illegal -> stay IDLE, next cycle
//     resp_valid=1 resp_err=1 rdata=0, MREQ never asserted.
//     Legal -> BUS; wait counter cleared.
//   BUS: MREQ=1, DAD=latched addr (unmodified), WRITE=req_write,
//     SIZE from funct3[1:0] (00->10, 01->01, 10->00); outputs held stable.
//     Store DDT: W wdata; H {16'h0,wdata[15:0]}; B {24'h0,wdata[7:0]}.
//     ACKD_n sampled each rising edge in BUS; ACKD_n==0 -> IDLE,
//     resp_valid=1 next cycle, resp_err=0. Load data captured from DDT at
//     that edge: B sext DDT[7:0], BU zext, H sext DDT[15:0], HU zext, W as-is.
//     No ack -> counter+1; counter==TIMEOUT_CYCLES-1 with no ack -> IDLE,
//     resp_valid=1 resp_err=1 rdata=0.
//   Latency: accept at edge N, zero-wait ack at edge N+1, resp_valid high
//     during cycle after N+1 (2 cycles). Each wait cycle adds 1.
//   resp_valid cycle is in IDLE: req_ready=1, back-to-back request accepted.
//   ACKD_n low while IDLE is ignored. MREQ deasserts the cycle after ack;
//     DDT released ('z) in that same cycle.
//   Addresses pass through unfiltered (STDOUT/EXIT stores are ordinary
//     byte/word stores to the bus).
// TESTING
//   LB 0x0800_0003, DDT=0x0000_00F0, ack 1st cycle -> SIZE=10, resp 2 cyc later,
//     rdata=0xFFFF_FFF0; repeat LBU -> 0x0000_00F0.
//   SW 0x0800_0010 wdata=0xDEAD_BEEF, ACKD_n held high 3 cycles -> MREQ/WRITE/DAD/DDT
//     stable 4 cycles, SIZE=00, single resp_valid, DDT='z afterwards.
//   SB 0xF000_0000 wdata=0x1234_5641 -> DDT=0x0000_0041 SIZE=10; back-to-back LH
//     0x0800_0002 DDT=0x0000_8001 accepted in resp cycle -> rdata=0xFFFF_8001.
//   LW 0x0800_0002 -> resp_err=1 next cycle, MREQ never 1; store funct3=100 -> err.
//   LW with ACKD_n never low, TIMEOUT_CYCLES=4 -> MREQ 4 cycles, resp_err=1, rdata=0.
//   rst low during BUS wait -> MREQ=0 after edge, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/dmem_bus_master_if.sv
// Request/response handshake plus data-memory bus control pins for dmem_bus_master.
// The bidirectional data lines (DDT) stay a plain inout on the module.
interface dmem_bus_master_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [2:0]           req_funct3;
    logic [BIT_WIDTH-1:0] req_addr;
    logic [BIT_WIDTH-1:0] req_wdata;

    logic                 resp_valid;
    logic                 resp_err;
    logic [BIT_WIDTH-1:0] resp_rdata;

    logic [BIT_WIDTH-1:0] DAD;
    logic                 MREQ;
    logic                 WRITE;
    logic [1:0]           SIZE;
    logic                 ACKD_n;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, ACKD_n,
        output req_ready, resp_valid, resp_err, resp_rdata, DAD, MREQ, WRITE, SIZE
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, ACKD_n,
        input  req_ready, resp_valid, resp_err, resp_rdata, DAD, MREQ, WRITE, SIZE
    );
endinterface

// File: rtl/dmem_bus_master.sv
// Data-memory bus initiator: one load/store at a time, formats store data, extends load data.
// Latency: response 2 cycles after accept plus one per wait cycle; req_ready low while the bus cycle is open.
module dmem_bus_master #(
    parameter int BIT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_bus_master_if.master    bus,
    inout  wire  [BIT_WIDTH-1:0] DDT
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic {IDLE, BUS} state_t;

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] addr_q;
    logic [2:0]           funct3_q;
    logic                 write_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 resp_valid_q;
    logic                 resp_err_q;
    logic [BIT_WIDTH-1:0] resp_rdata_q;

    logic                 accept;
    logic                 illegal;
    logic                 ack;
    logic                 timeout;
    logic [BIT_WIDTH-1:0] wdata_fmt;
    logic [BIT_WIDTH-1:0] load_ext;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign ack     = (state_q == BUS) && !bus.ACKD_n;
    assign timeout = (state_q == BUS) && bus.ACKD_n &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        illegal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = bus.req_addr[0];
            3'b010:         illegal = (bus.req_addr[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
        // Unsigned widths only make sense for loads.
        if (bus.req_write && bus.req_funct3[2])
            illegal = 1'b1;
    end

    always_comb begin
        wdata_fmt = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00:   wdata_fmt = BIT_WIDTH'(bus.req_wdata[7:0]);
            2'b01:   wdata_fmt = BIT_WIDTH'(bus.req_wdata[15:0]);
            default: wdata_fmt = bus.req_wdata;
        endcase
    end

    always_comb begin
        load_ext = DDT;
        case (funct3_q)
            3'b000:  load_ext = {{(BIT_WIDTH-8){DDT[7]}}, DDT[7:0]};
            3'b100:  load_ext = BIT_WIDTH'(DDT[7:0]);
            3'b001:  load_ext = {{(BIT_WIDTH-16){DDT[15]}}, DDT[15:0]};
            3'b101:  load_ext = BIT_WIDTH'(DDT[15:0]);
            default: load_ext = DDT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !illegal) state_d = BUS;
            BUS:     if (ack || timeout)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q       <= '0;
            funct3_q     <= 3'b000;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            if (accept) begin
                addr_q   <= bus.req_addr;
                funct3_q <= bus.req_funct3;
                write_q  <= bus.req_write;
                wdata_q  <= wdata_fmt;
                cnt_q    <= '0;
                if (illegal) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                end
            end
            if (state_q == BUS) begin
                if (ack) begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= write_q ? '0 : load_ext;
                end else if (timeout) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Output logic: bus pins are parked at zero outside a bus cycle.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.MREQ       = (state_q == BUS);
        bus.DAD        = (state_q == BUS) ? addr_q : '0;
        bus.WRITE      = (state_q == BUS) && write_q;
        bus.SIZE       = 2'b00;
        if (state_q == BUS) begin
            case (funct3_q[1:0])
                2'b00:   bus.SIZE = 2'b10;
                2'b01:   bus.SIZE = 2'b01;
                default: bus.SIZE = 2'b00;
            endcase
        end
        bus.resp_valid = resp_valid_q;
        bus.resp_err   = resp_err_q;
        bus.resp_rdata = resp_rdata_q;
    end

    assign DDT = ((state_q == BUS) && write_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed bench for dmem_bus_master: loads/stores, back-to-back, illegal requests, timeout, reset abort.
// The bench owns DDT whenever the master must have released it, so a stuck driver shows up as a bad value.
module tb_dmem_bus_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        tb_drv;
    logic [31:0] tb_ddt;
    wire  [31:0] ddt;
    int          n_chk  = 0;
    int          n_pass = 0;

    dmem_bus_master_if #(.BIT_WIDTH(32)) bus ();

    assign ddt = tb_drv ? tb_ddt : 'z;

    dmem_bus_master #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master),
        .DDT (ddt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.ACKD_n     = 1'b1;
        tb_drv         = 1'b1;
        tb_ddt         = 32'h0;
        tick();
        tick();
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mreq", {31'h0, bus.MREQ}, 32'h0);
        check("rst_write", {31'h0, bus.WRITE}, 32'h0);
        check("rst_size", {30'h0, bus.SIZE}, 32'h0);
        check("rst_dad", bus.DAD, 32'h0);
        check("rst_ddt_released", ddt, 32'h0);
        rst = 1'b1;
        tick();

        // LB with immediate ack
        tb_ddt = 32'h0000_00F0;
        issue(1'b0, 3'b000, 32'h0800_0003, 32'h0);
        check("lb_mreq", {31'h0, bus.MREQ}, 32'h1);
        check("lb_size", {30'h0, bus.SIZE}, 32'h2);
        check("lb_dad", bus.DAD, 32'h0800_0003);
        check("lb_write", {31'h0, bus.WRITE}, 32'h0);
        check("lb_req_ready", {31'h0, bus.req_ready}, 32'h0);
        check("lb_no_early_resp", {31'h0, bus.resp_valid}, 32'h0);
        bus.ACKD_n = 1'b0;
        tick();
        check("lb_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        check("lb_resp_err", {31'h0, bus.resp_err}, 32'h0);
        check("lb_rdata", bus.resp_rdata, 32'hFFFF_FFF0);
        check("lb_mreq_drop", {31'h0, bus.MREQ}, 32'h0);
        check("lb_ready_in_resp", {31'h0, bus.req_ready}, 32'h1);
        bus.ACKD_n = 1'b1;
        tick();
        check("lb_resp_pulse", {31'h0, bus.resp_valid}, 32'h0);

        // LBU same byte
        issue(1'b0, 3'b100, 32'h0800_0003, 32'h0);
        check("lbu_size", {30'h0, bus.SIZE}, 32'h2);
        bus.ACKD_n = 1'b0;
        tick();
        check("lbu_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        check("lbu_rdata", bus.resp_rdata, 32'h0000_00F0);
        bus.ACKD_n = 1'b1;
        tick();

        // SW with three wait cycles
        tb_drv = 1'b0;
        issue(1'b1, 3'b010, 32'h0800_0010, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw_mreq_%0d", i), {31'h0, bus.MREQ}, 32'h1);
            check($sformatf("sw_write_%0d", i), {31'h0, bus.WRITE}, 32'h1);
            check($sformatf("sw_dad_%0d", i), bus.DAD, 32'h0800_0010);
            check($sformatf("sw_ddt_%0d", i), ddt, 32'hDEAD_BEEF);
            check($sformatf("sw_size_%0d", i), {30'h0, bus.SIZE}, 32'h0);
            check($sformatf("sw_no_resp_%0d", i), {31'h0, bus.resp_valid}, 32'h0);
            if (i == 3) bus.ACKD_n = 1'b0;
            tick();
        end
        check("sw_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        check("sw_resp_err", {31'h0, bus.resp_err}, 32'h0);
        check("sw_rdata", bus.resp_rdata, 32'h0);
        check("sw_mreq_drop", {31'h0, bus.MREQ}, 32'h0);
        tb_drv = 1'b1;
        tb_ddt = 32'h0;
        #1;
        check("sw_ddt_released", ddt, 32'h0);
        bus.ACKD_n = 1'b1;
        tick();
        check("sw_single_resp", {31'h0, bus.resp_valid}, 32'h0);

        // SB then back-to-back LH accepted in the response cycle
        tb_drv = 1'b0;
        issue(1'b1, 3'b000, 32'hF000_0000, 32'h1234_5641);
        check("sb_ddt", ddt, 32'h0000_0041);
        check("sb_size", {30'h0, bus.SIZE}, 32'h2);
        check("sb_dad", bus.DAD, 32'hF000_0000);
        bus.ACKD_n = 1'b0;
        tick();
        check("sb_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        check("sb_ready_in_resp", {31'h0, bus.req_ready}, 32'h1);
        bus.ACKD_n = 1'b1;
        tb_drv     = 1'b1;
        tb_ddt     = 32'h0000_8001;
        issue(1'b0, 3'b001, 32'h0800_0002, 32'h0);
        check("lh_mreq", {31'h0, bus.MREQ}, 32'h1);
        check("lh_size", {30'h0, bus.SIZE}, 32'h1);
        check("lh_write", {31'h0, bus.WRITE}, 32'h0);
        check("lh_dad", bus.DAD, 32'h0800_0002);
        bus.ACKD_n = 1'b0;
        tick();
        check("lh_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        check("lh_rdata", bus.resp_rdata, 32'hFFFF_8001);
        bus.ACKD_n = 1'b1;
        tick();

        // Misaligned LW: error response, bus untouched
        issue(1'b0, 3'b010, 32'h0800_0002, 32'h0);
        check("lw_mis_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        check("lw_mis_resp_err", {31'h0, bus.resp_err}, 32'h1);
        check("lw_mis_rdata", bus.resp_rdata, 32'h0);
        check("lw_mis_mreq", {31'h0, bus.MREQ}, 32'h0);
        tick();
        check("lw_mis_mreq_after", {31'h0, bus.MREQ}, 32'h0);
        check("lw_mis_resp_pulse", {31'h0, bus.resp_valid}, 32'h0);

        // Store with unsigned-width funct3
        issue(1'b1, 3'b100, 32'h0800_0000, 32'h55);
        check("st_bu_resp_err", {31'h0, bus.resp_err}, 32'h1);
        check("st_bu_mreq", {31'h0, bus.MREQ}, 32'h0);
        tick();

        // Undefined funct3 load
        issue(1'b0, 3'b011, 32'h0800_0000, 32'h0);
        check("ld_011_resp_err", {31'h0, bus.resp_err}, 32'h1);
        check("ld_011_mreq", {31'h0, bus.MREQ}, 32'h0);
        tick();

        // Timeout: no ack for TIMEOUT_CYCLES bus cycles
        tb_ddt = 32'h1234_5678;
        issue(1'b0, 3'b010, 32'h0800_0004, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_mreq_%0d", i), {31'h0, bus.MREQ}, 32'h1);
            check($sformatf("to_no_resp_%0d", i), {31'h0, bus.resp_valid}, 32'h0);
            tick();
        end
        check("to_mreq_drop", {31'h0, bus.MREQ}, 32'h0);
        check("to_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        check("to_resp_err", {31'h0, bus.resp_err}, 32'h1);
        check("to_rdata", bus.resp_rdata, 32'h0);
        tick();

        // Reset during a bus wait aborts without a response
        issue(1'b0, 3'b010, 32'h0800_0008, 32'h0);
        check("ra_mreq", {31'h0, bus.MREQ}, 32'h1);
        rst = 1'b0;
        tick();
        check("ra_mreq_drop", {31'h0, bus.MREQ}, 32'h0);
        check("ra_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("ra_no_resp", {31'h0, bus.resp_valid}, 32'h0);
        rst        = 1'b1;
        bus.ACKD_n = 1'b0;
        tick();
        check("ra_idle_ack_ignored", {31'h0, bus.resp_valid}, 32'h0);
        check("ra_still_idle", {31'h0, bus.MREQ}, 32'h0);
        bus.ACKD_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
